// File: rtl/op2_shift_stage.sv
// op2_shift_stage: operand-2 stage; in_* accepts an instruction, rf_* reads Rm/Rs, out_* returns op2 and shifter carry
module op2_shift_stage #(
  parameter int RF_RD_PORTS = 1,
  parameter bit OUT_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  input  logic        in_c,
  output logic [3:0]  rf_raddr0,
  input  logic [31:0] rf_rdata0,
  output logic [3:0]  rf_raddr1,
  input  logic [31:0] rf_rdata1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op2,
  output logic        out_c
);
  typedef enum logic [1:0] {IDLE, RD_RM, RD_RS, DONE} state_t;
  state_t state, state_nx;
  logic [12:0] code;
  logic        c_q;
  logic [31:0] rm_q;
  logic [32:0] res;
  logic        one_pass, load_res, unused;
  function automatic logic [32:0] shift_n(input logic [1:0] typ, input logic [31:0] rm, input logic [4:0] n);
    logic [32:0] l, r, a;
    logic [63:0] o;
    l = {1'b0, rm} << n;
    r = {rm, 1'b0} >> n;
    a = $signed({rm, 1'b0}) >>> n;
    o = {rm, rm} >> n;
    return typ == 2'd0 ? l : typ == 2'd1 ? {r[0], r[32:1]} : typ == 2'd2 ? {a[0], a[32:1]} : {r[0], o[31:0]};
  endfunction
  function automatic logic [32:0] calc(input logic [12:0] cd, input logic [31:0] rm, input logic [7:0] amt, input logic c_in);
    logic [63:0] imm;
    logic [1:0]  t;
    logic [31:0] sgn;
    imm = {2{24'd0, cd[7:0]}} >> {cd[11:8], 1'b0};
    t = cd[6:5];
    sgn = {32{rm[31]}};
    if (cd[12]) return {cd[11:8] == 4'd0 ? c_in : imm[31], imm[31:0]};
    if (!cd[4]) begin
      if (cd[11:7] != 5'd0) return shift_n(t, rm, cd[11:7]);
      return t == 2'd0 ? {c_in, rm} : t == 2'd1 ? {rm[31], 32'd0} : t == 2'd2 ? {rm[31], sgn} : {rm[0], c_in, rm[31:1]};
    end
    if (amt == 8'd0) return {c_in, rm};
    if (t == 2'd3) return amt[4:0] == 5'd0 ? {rm[31], rm} : shift_n(t, rm, amt[4:0]);
    if (amt < 8'd32) return shift_n(t, rm, amt[4:0]);
    if (t == 2'd2) return {rm[31], sgn};
    return amt == 8'd32 ? {t == 2'd0 ? rm[0] : rm[31], 32'd0} : 33'd0;
  endfunction
  assign one_pass = code[12] || !code[4] || RF_RD_PORTS == 2;
  assign unused = ^{in_code[31:26], in_code[24:12], rf_rdata1[31:8]};
  always_comb begin
    in_ready = !rst && !flush && (state == IDLE || (OUT_BYPASS && state == DONE && out_ready));
    out_valid = !rst && state == DONE;
    rf_raddr0 = state == RD_RS ? code[11:8] : code[3:0];
    rf_raddr1 = RF_RD_PORTS == 2 ? code[11:8] : 4'd0;
    res = calc(code, state == RD_RS ? rm_q : rf_rdata0,
               state == RD_RS || RF_RD_PORTS != 2 ? rf_rdata0[7:0] : rf_rdata1[7:0], c_q);
    load_res = !flush && (state == RD_RS || (state == RD_RM && one_pass));
    state_nx = flush ? IDLE :
               state == IDLE ? (in_valid ? RD_RM : IDLE) :
               state == RD_RM ? (one_pass ? DONE : RD_RS) :
               state == RD_RS ? DONE :
               out_ready ? (in_valid && in_ready ? RD_RM : IDLE) : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code <= '0;
      c_q <= 1'b0;
      rm_q <= '0;
      out_op2 <= '0;
      out_c <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_valid && in_ready) begin
        code <= {in_code[25], in_code[11:0]};
        c_q <= in_c;
      end
      if (state == RD_RM && !one_pass) rm_q <= rf_rdata0;
      if (load_res) {out_c, out_op2} <= res;
    end
  end
endmodule
